led_adc_sequencer: RTL

LED_ADC_SEQUENCER -- requirements
Module: led_adc_sequencer

---
 rtl/led_adc_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/led_adc_sequencer.sv
// led_adc_sequencer: alternates IR/red LED phases and requests one ADC conversion per phase, latching each result per channel.
// Latency: adc_start at phase_cnt == SETTLE_CYCLES; channel value and its strobe appear 1 cycle after adc_valid.
// Backpressure: none; a phase ending without an ADC answer sets sticky adc_timeout_err. Optional macro LED_BLANK_EN: 1-cycle LED dead time at phase_cnt 0.
module led_adc_sequencer #(
   parameter int PHASE_CYCLES  = 50,
   parameter int SETTLE_CYCLES = 20
) (
   input  logic       CLK_Filter,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] adc_data,
   input  logic       adc_valid,
   output logic       adc_start,
   output logic       LED_IR,
   output logic       LED_RED,
   output logic [7:0] IR_ADC_Value,
   output logic [7:0] RED_ADC_Value,
   output logic       ir_sample_stb,
   output logic       red_sample_stb,
   output logic       adc_timeout_err
);

   typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT, HOLD} state_t;

   localparam logic [7:0] LP_PHASE_LAST  = 8'(PHASE_CYCLES - 1);
   localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

`ifdef LED_BLANK_EN
   localparam logic LP_BLANK = 1'b1;
`else
   localparam logic LP_BLANK = 1'b0;
`endif

   state_t     r_state;
   logic [7:0] r_phase_cnt;
   logic       r_ch;
   logic       r_adc_start;
   logic       r_led_ir;
   logic       r_led_red;
   logic [7:0] r_ir_val;
   logic [7:0] r_red_val;
   logic       r_ir_stb;
   logic       r_red_stb;
   logic       r_err;

   // LED drive for the coming cycle: on when its channel is active, blanked at phase_cnt 0 if dead time is built in
   function automatic logic led_on(input logic ch_match, input logic cnt_zero);
      led_on = ch_match && !(LP_BLANK && cnt_zero);
   endfunction

   // Sequencer FSM: phase timing, conversion request, sample capture and all registered outputs
   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_phase_cnt <= 8'd0;
         r_ch        <= 1'b0;
         r_adc_start <= 1'b0;
         r_led_ir    <= 1'b0;
         r_led_red   <= 1'b0;
         r_ir_val    <= 8'd0;
         r_red_val   <= 8'd0;
         r_ir_stb    <= 1'b0;
         r_red_stb   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_adc_start <= 1'b0;
         r_ir_stb    <= 1'b0;
         r_red_stb   <= 1'b0;
         if (!enable) begin
            // stopping always parks on IR so a restart begins with the IR phase
            r_state     <= IDLE;
            r_phase_cnt <= 8'd0;
            r_ch        <= 1'b0;
            r_led_ir    <= 1'b0;
            r_led_red   <= 1'b0;
         end else if (r_state == IDLE) begin
            r_state     <= SETTLE;
            r_phase_cnt <= 8'd0;
            r_ch        <= 1'b0;
            r_led_ir    <= led_on(1'b1, 1'b1);
            r_led_red   <= 1'b0;
         end else if (r_phase_cnt == LP_PHASE_LAST) begin
            // phase end wins over every state; a late-but-in-time sample is still taken
            if (r_state == WAIT) begin
               if (adc_valid) begin
                  if (r_ch) begin
                     r_red_val <= adc_data;
                     r_red_stb <= 1'b1;
                  end else begin
                     r_ir_val <= adc_data;
                     r_ir_stb <= 1'b1;
                  end
               end else begin
                  r_err <= 1'b1;
               end
            end
            r_state     <= SETTLE;
            r_phase_cnt <= 8'd0;
            r_ch        <= ~r_ch;
            r_led_ir    <= led_on(r_ch, 1'b1);
            r_led_red   <= led_on(~r_ch, 1'b1);
         end else begin
            r_phase_cnt <= r_phase_cnt + 8'd1;
            r_led_ir    <= led_on(~r_ch, 1'b0);
            r_led_red   <= led_on(r_ch, 1'b0);
            case (r_state)
               SETTLE: begin
                  if (r_phase_cnt == LP_SETTLE_LAST) begin
                     r_state     <= CONVERT;
                     r_adc_start <= 1'b1;
                  end
               end
               CONVERT: r_state <= WAIT;
               WAIT: begin
                  if (adc_valid) begin
                     if (r_ch) begin
                        r_red_val <= adc_data;
                        r_red_stb <= 1'b1;
                     end else begin
                        r_ir_val <= adc_data;
                        r_ir_stb <= 1'b1;
                     end
                     r_state <= HOLD;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign adc_start       = r_adc_start;
   assign LED_IR          = r_led_ir;
   assign LED_RED         = r_led_red;
   assign IR_ADC_Value    = r_ir_val;
   assign RED_ADC_Value   = r_red_val;
   assign ir_sample_stb   = r_ir_stb;
   assign red_sample_stb  = r_red_stb;
   assign adc_timeout_err = r_err;

endmodule
